// File: rtl/pipe_hazard_ctrl.sv
// Valid/allowin sequencer for a 5-stage IF/ID/EX/MEM/WB pipeline: RAW scoreboard, load wait, flush.
// Define PIPE_HAZARD_FWD_EN when the datapath has full bypass (stall only on load-use).
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic              id_rs1_en,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs2_en,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic              ex_br_taken,
    output logic              if_allowin,
    output logic              id_allowin,
    output logic              ex_allowin,
    output logic              mem_allowin,
    output logic              id_ready_go,
    output logic              mem_ready_go,
    output logic              id_valid,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int unsigned LatW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LatW-1:0] LatLast = LatW'(MEM_LAT - 1);

    logic [REG_AW-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
    logic              ex_rd_we_q, mem_rd_we_q, wb_rd_we_q;
    logic              ex_is_load_q, mem_is_load_q;
    logic [LatW-1:0]   mem_cnt_q;

    logic wb_allowin, ex_ready_go;
    logic ex_counted, mem_counted, wb_counted;
    logic ex_hit, mem_hit, wb_hit;

    assign wb_allowin  = 1'b1;
    assign ex_ready_go = 1'b1;

    // A scoreboard entry only matters when it holds a live write to a non-zero register.
    always_comb begin
        ex_counted  = ex_valid & ex_rd_we_q & (ex_rd_q != '0);
        mem_counted = mem_valid & mem_rd_we_q & (mem_rd_q != '0);
        wb_counted  = wb_valid & wb_rd_we_q & (wb_rd_q != '0);
        ex_hit  = ex_counted & ((id_rs1_en & (id_rs1 == ex_rd_q)) |
                                (id_rs2_en & (id_rs2 == ex_rd_q)));
        mem_hit = mem_counted & ((id_rs1_en & (id_rs1 == mem_rd_q)) |
                                 (id_rs2_en & (id_rs2 == mem_rd_q)));
        wb_hit  = wb_counted & ((id_rs1_en & (id_rs1 == wb_rd_q)) |
                                (id_rs2_en & (id_rs2 == wb_rd_q)));
    end

    always_comb begin
        mem_ready_go = ~(mem_valid & mem_is_load_q) | (mem_cnt_q == LatLast);
`ifdef PIPE_HAZARD_FWD_EN
        id_ready_go  = ~((ex_hit & ex_is_load_q) | (mem_hit & mem_is_load_q & ~mem_ready_go));
`else
        id_ready_go  = ~(ex_hit | mem_hit | wb_hit);
`endif
    end

    always_comb begin
        mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin);
        ex_allowin  = ~ex_valid | (ex_ready_go & mem_allowin);
        id_allowin  = ~id_valid | (id_ready_go & ex_allowin);
        flush       = ~rst & ex_valid & ex_br_taken & mem_allowin;
        if_allowin  = id_allowin | flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid  <= 1'b0;
            ex_valid  <= 1'b0;
            mem_valid <= 1'b0;
            wb_valid  <= 1'b0;
        end else begin
            if (flush) begin
                id_valid <= 1'b0;
            end else if (id_allowin) begin
                id_valid <= if_valid;
            end
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (ex_allowin) begin
                ex_valid <= id_valid & id_ready_go;
            end
            if (mem_allowin) begin
                mem_valid <= ex_valid & ex_ready_go;
            end
            if (wb_allowin) begin
                wb_valid <= mem_valid & mem_ready_go;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rd_q       <= '0;
            ex_rd_we_q    <= 1'b0;
            ex_is_load_q  <= 1'b0;
            mem_rd_q      <= '0;
            mem_rd_we_q   <= 1'b0;
            mem_is_load_q <= 1'b0;
            wb_rd_q       <= '0;
            wb_rd_we_q    <= 1'b0;
        end else begin
            if (ex_allowin && !flush) begin
                ex_rd_q      <= id_rd;
                ex_rd_we_q   <= id_rd_we;
                ex_is_load_q <= id_is_load;
            end
            if (mem_allowin) begin
                mem_rd_q      <= ex_rd_q;
                mem_rd_we_q   <= ex_rd_we_q;
                mem_is_load_q <= ex_is_load_q;
            end
            if (wb_allowin) begin
                wb_rd_q    <= mem_rd_q;
                wb_rd_we_q <= mem_rd_we_q;
            end
        end
    end

    // MEM only holds when a load is still waiting, so any MEM load restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_cnt_q <= '0;
        end else if (mem_allowin) begin
            mem_cnt_q <= '0;
        end else if (mem_valid && mem_is_load_q) begin
            mem_cnt_q <= mem_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (id_valid && !id_ready_go && !flush && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_LAT = 2, CNT_W = 4).
module tb_pipe_hazard_ctrl;
`ifdef PIPE_HAZARD_FWD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    logic       clk, rst;
    logic       if_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_en, id_rs2_en, id_rd_we, id_is_load, ex_br_taken;
    logic       if_allowin, id_allowin, ex_allowin, mem_allowin;
    logic       id_ready_go, mem_ready_go;
    logic       id_valid, ex_valid, mem_valid, wb_valid, flush;
    logic [3:0] stall_cnt;
    logic [3:0] valids;

    int checks   = 0;
    int failures = 0;

    assign valids = {id_valid, ex_valid, mem_valid, wb_valid};

    pipe_hazard_ctrl #(.REG_AW(5), .MEM_LAT(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid),
        .id_rs1(id_rs1), .id_rs1_en(id_rs1_en), .id_rs2(id_rs2), .id_rs2_en(id_rs2_en),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load), .ex_br_taken(ex_br_taken),
        .if_allowin(if_allowin), .id_allowin(id_allowin), .ex_allowin(ex_allowin),
        .mem_allowin(mem_allowin), .id_ready_go(id_ready_go), .mem_ready_go(mem_ready_go),
        .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .flush(flush), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        if_valid = 1'b0; id_rs1 = '0; id_rs1_en = 1'b0; id_rs2 = '0; id_rs2_en = 1'b0;
        id_rd = '0; id_rd_we = 1'b0; id_is_load = 1'b0; ex_br_taken = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (valids !== 4'b0000) begin failures++;
            $display("FAIL reset_valids got=%b exp=0000", valids); end
        checks++; if (stall_cnt !== 4'd0) begin failures++;
            $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        rst = 1'b0;
        if_valid = 1'b1;
        repeat (4) step();
        checks++; if (valids !== 4'b1111) begin failures++;
            $display("FAIL fill_valids got=%b exp=1111", valids); end
        ex_br_taken = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++; if (valids !== 4'b0000) begin failures++;
            $display("FAIL midreset_valids got=%b exp=0000", valids); end
        checks++; if (stall_cnt !== 4'd0) begin failures++;
            $display("FAIL midreset_stall_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (flush !== 1'b0) begin failures++;
            $display("FAIL midreset_flush got=%b exp=0", flush); end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_stream();
        do_reset();
        if_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++; if (wb_valid !== (k >= 4)) begin failures++;
                $display("FAIL stream_wb_valid edge=%0d got=%b exp=%b", k, wb_valid, k >= 4); end
            checks++; if (id_ready_go !== 1'b1) begin failures++;
                $display("FAIL stream_ready_go edge=%0d got=%b exp=1", k, id_ready_go); end
        end
        if_valid = 1'b0;
        repeat (4) step();
        checks++; if (valids !== 4'b0000) begin failures++;
            $display("FAIL stream_drain got=%b exp=0000", valids); end
        checks++; if (stall_cnt !== 4'd0) begin failures++;
            $display("FAIL stream_stall_cnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_raw_alu();
        logic       exp_go;
        logic [3:0] exp_cnt;
        do_reset();
        if_valid = 1'b1;
        step();
        id_rd = 5'd5; id_rd_we = 1'b1;
        #1;
        checks++; if (id_ready_go !== 1'b1) begin failures++;
            $display("FAIL alu_producer_go got=%b exp=1", id_ready_go); end
        step();
        if_valid = 1'b0; id_rd = '0; id_rd_we = 1'b0; id_rs1 = 5'd5; id_rs1_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_go = Fwd | (i == 3);
            checks++; if (id_ready_go !== exp_go) begin failures++;
                $display("FAIL alu_raw_go cyc=%0d got=%b exp=%b", i, id_ready_go, exp_go); end
            step();
        end
        exp_cnt = Fwd ? 4'd0 : 4'd3;
        checks++; if (stall_cnt !== exp_cnt) begin failures++;
            $display("FAIL alu_raw_stall_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
        checks++; if (id_valid !== 1'b0) begin failures++;
            $display("FAIL alu_consumer_left got=%b exp=0", id_valid); end
    endtask

    task automatic test_load_use();
        logic [3:0] exp_go, exp_mrg, exp_mal;
        logic [3:0] exp_cnt;
        do_reset();
        if_valid = 1'b1;
        step();
        id_rd = 5'd7; id_rd_we = 1'b1; id_is_load = 1'b1;
        step();
        if_valid = 1'b0; id_rd = '0; id_rd_we = 1'b0; id_is_load = 1'b0;
        id_rs2 = 5'd7; id_rs2_en = 1'b1;
        exp_go  = Fwd ? 4'b1100 : 4'b0000;
        exp_mrg = 4'b1101;
        exp_mal = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (id_ready_go !== exp_go[i]) begin failures++;
                $display("FAIL load_go cyc=%0d got=%b exp=%b", i, id_ready_go, exp_go[i]); end
            checks++; if (mem_ready_go !== exp_mrg[i]) begin failures++;
                $display("FAIL load_mem_ready_go cyc=%0d got=%b exp=%b", i, mem_ready_go,
                         exp_mrg[i]); end
            checks++; if (mem_allowin !== exp_mal[i]) begin failures++;
                $display("FAIL load_mem_allowin cyc=%0d got=%b exp=%b", i, mem_allowin,
                         exp_mal[i]); end
            step();
        end
        #1;
        checks++; if (id_ready_go !== 1'b1) begin failures++;
            $display("FAIL load_go_after got=%b exp=1", id_ready_go); end
        exp_cnt = Fwd ? 4'd2 : 4'd4;
        checks++; if (stall_cnt !== exp_cnt) begin failures++;
            $display("FAIL load_stall_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
    endtask

    task automatic test_flush();
        logic exp_go;
        do_reset();
        if_valid = 1'b1;
        step();
        id_rd = 5'd3; id_rd_we = 1'b1;
        step();
        id_rd = '0; id_rd_we = 1'b0;
        step();
        id_rs1 = 5'd3; id_rs1_en = 1'b1; ex_br_taken = 1'b1;
        #1;
        checks++; if (flush !== 1'b1) begin failures++;
            $display("FAIL flush_pulse got=%b exp=1", flush); end
        checks++; if (if_allowin !== 1'b1) begin failures++;
            $display("FAIL flush_if_allowin got=%b exp=1", if_allowin); end
        exp_go = Fwd;
        checks++; if (id_ready_go !== exp_go) begin failures++;
            $display("FAIL flush_id_stall got=%b exp=%b", id_ready_go, exp_go); end
        step();
        ex_br_taken = 1'b0; id_rs1_en = 1'b0; if_valid = 1'b0;
        #1;
        checks++; if (valids !== 4'b0011) begin failures++;
            $display("FAIL flush_bubble got=%b exp=0011", valids); end
        checks++; if (stall_cnt !== 4'd0) begin failures++;
            $display("FAIL flush_stall_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (flush !== 1'b0) begin failures++;
            $display("FAIL flush_one_cycle got=%b exp=0", flush); end
    endtask

    task automatic test_flush_backpressure();
        do_reset();
        if_valid = 1'b1;
        step();
        id_rd = 5'd9; id_rd_we = 1'b1; id_is_load = 1'b1;
        step();
        id_rd = '0; id_rd_we = 1'b0; id_is_load = 1'b0;
        step();
        ex_br_taken = 1'b1;
        #1;
        checks++; if (flush !== 1'b0) begin failures++;
            $display("FAIL bp_no_flush got=%b exp=0", flush); end
        checks++; if (ex_allowin !== 1'b0) begin failures++;
            $display("FAIL bp_ex_allowin got=%b exp=0", ex_allowin); end
        checks++; if (id_allowin !== 1'b0) begin failures++;
            $display("FAIL bp_id_allowin got=%b exp=0", id_allowin); end
        step();
        #1;
        checks++; if (flush !== 1'b1) begin failures++;
            $display("FAIL bp_late_flush got=%b exp=1", flush); end
        step();
        ex_br_taken = 1'b0;
        #1;
        checks++; if (valids !== 4'b0011) begin failures++;
            $display("FAIL bp_bubble got=%b exp=0011", valids); end
    endtask

    task automatic test_zero_sat();
        do_reset();
        if_valid = 1'b1; id_rd = '0; id_rd_we = 1'b1; id_rs1 = '0; id_rs1_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            checks++; if (id_ready_go !== 1'b1) begin failures++;
                $display("FAIL r0_no_stall cyc=%0d got=%b exp=1", i, id_ready_go); end
        end
        checks++; if (stall_cnt !== 4'd0) begin failures++;
            $display("FAIL r0_stall_cnt got=%0d exp=0", stall_cnt); end
        // Every instruction reads the r5 load of its predecessor: a steady stall stream.
        id_rd = 5'd5; id_rs1 = 5'd5; id_is_load = 1'b1;
        repeat (40) step();
        checks++; if (stall_cnt !== 4'hf) begin failures++;
            $display("FAIL sat_value got=%0d exp=15", stall_cnt); end
        repeat (5) step();
        checks++; if (stall_cnt !== 4'hf) begin failures++;
            $display("FAIL sat_hold got=%0d exp=15", stall_cnt); end
        #2 rst = 1'b1;
        #1;
        checks++; if (stall_cnt !== 4'd0) begin failures++;
            $display("FAIL sat_reset got=%0d exp=0", stall_cnt); end
        checks++; if (valids !== 4'b0000) begin failures++;
            $display("FAIL sat_reset_valids got=%b exp=0000", valids); end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_stream();
        test_raw_alu();
        test_load_use();
        test_flush();
        test_flush_backpressure();
        test_zero_sat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
